fir_out_monitor: RTL and testbench
==================================

FIR_OUT_MONITOR -- requirements
Module: fir_out_monitor

Interface
REQ-001 SHALL have parameter DWELL, default 50000000, cycles each byte is displayed before the display switches to the other byte (minimum 2).
REQ-002 SHALL have parameter STRETCH, default 5000000, cycles LEDG stays lit after an accepted sample (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: when low, all state holds and samples are ignored.
REQ-006 SHALL have port rIn, input, 1 bit: sample-valid strobe from the FIR stage.
REQ-007 SHALL have port dataIn, input, 16 bits: FIR output sample, unsigned.
REQ-008 SHALL have port peak_sel, input, 1 bit: 1 selects the peak value for display, 0 selects the last sample.
REQ-009 SHALL have port peak_clr, input, 1 bit: synchronous clear of the peak register.
REQ-010 SHALL have port LEDG, output, 1 bit: activity indicator.
REQ-011 SHALL have port HEX0, output, 7 bits: low nibble of the displayed byte, segments active-low, bit0=a..bit6=g.
REQ-012 SHALL have port HEX1, output, 7 bits: high nibble of the displayed byte, same encoding as HEX0.

Function
REQ-013 SHALL register dataIn into last_q on each clk edge where enable=1 and rIn=1; the value is visible on the display path one cycle later.
REQ-014 SHALL update peak_q to dataIn when a sample is accepted and dataIn > peak_q (unsigned compare); equal values do not update peak_q.
REQ-015 SHALL give peak_clr priority over a same-cycle sample: peak_q loads 0, and the simultaneous sample updates last_q only.
REQ-016 SHALL implement FSM states SHOW_HI and SHOW_LO with a dwell counter, 0..DWELL-1.
REQ-017 SHALL, in SHOW_HI, display bits [15:8] of the selected value; in SHOW_LO, display bits [7:0].
REQ-018 SHALL, when the dwell counter reaches DWELL-1, wrap it to 0 and toggle the state; counter and state advance only while enable=1.
REQ-019 SHALL load the LED stretch counter with STRETCH on each accepted sample; a re-trigger while nonzero reloads it; it decrements to 0 otherwise.
REQ-020 SHALL drive LEDG=1 exactly while the stretch counter is nonzero; LEDG is registered.
REQ-021 SHALL register HEX0 and HEX1, giving one cycle of latency from the selected byte to the pins.
REQ-022 SHALL make a peak_sel change take effect on the next registered HEX update, without resetting the FSM.

Reset
REQ-023 SHALL, with rst=0 at any time including mid-dwell or mid-stretch, immediately clear last_q, peak_q, the dwell counter and the stretch counter, set the state to SHOW_HI, set LEDG=0, and set HEX0=HEX1=7'b1000000 (glyph "0").
REQ-024 SHALL, on rst release, resume operation from the first rising clk edge.

Configuration
REQ-025 SHALL use macro FIR_MON_PEAK_HOLD_EN: when defined, peak_q, peak_sel and peak_clr behave as specified above.
REQ-026 SHALL, when FIR_MON_PEAK_HOLD_EN is undefined, omit peak_q; peak_sel and peak_clr remain as ports but are ignored, and the display always shows last_q.

Structure
REQ-027 SHALL take the FSM state encoding (SHOW_HI=1'b1, SHOW_LO=1'b0) and the 16-entry active-low seven-segment table from shared package fir_mon_pkg.
REQ-028 SHALL instantiate combinational sub-module seg7_decode (4-bit nibble in, 7-bit segments out) twice, once for HEX0 and once for HEX1.

Verification (DWELL=4, STRETCH=3)
REQ-029 SHALL cover: reset, then sample 0x12AB -> HEX1/HEX0 show "1","2" for 4 cycles, then "A","b" for 4 cycles, repeating.
REQ-030 SHALL cover: samples 0x0100, 0x0300, 0x0200 with peak_sel=1 -> display shows 0x0300; with peak_sel=0 -> display shows 0x0200.
REQ-031 SHALL cover: peak_clr and sample 0x0050 in the same cycle -> peak_q=0, last_q=0x0050.
REQ-032 SHALL cover: a single rIn pulse -> LEDG high for exactly 3 cycles; a second pulse 2 cycles after the first -> LEDG stays high for 3 cycles after the second pulse.
REQ-033 SHALL cover: enable=0 for 10 cycles mid-dwell -> the state, dwell count and LEDG are frozen, and an rIn asserted during that window is ignored.
REQ-034 SHALL cover: rst asserted mid-stretch in SHOW_LO -> LEDG=0, HEX0=HEX1=7'b1000000 immediately (asynchronously), and the state is SHOW_HI after release.

Source files
------------

// File: rtl/fir_mon_pkg.sv
// Shared types and constants for the FIR output monitor: display FSM encoding
// and the active-low seven-segment glyph table (bit0=a .. bit6=g).
package fir_mon_pkg;

  typedef enum logic {
    SHOW_LO = 1'b0,
    SHOW_HI = 1'b1
  } state_e;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_decode
  import fir_mon_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/fir_out_monitor.sv
// Shows the FIR output (last sample, or held peak) one byte at a time on two
// hex digits, alternating bytes every DWELL cycles, with a stretched activity LED.
// Optional peak-hold register enabled by defining FIR_MON_PEAK_HOLD_EN.
module fir_out_monitor
  import fir_mon_pkg::*;
#(
  parameter int DWELL   = 50000000,
  parameter int STRETCH = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rIn,
  input  logic [15:0] dataIn,
  input  logic        peak_sel,
  input  logic        peak_clr,
  output logic        LEDG,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW = $clog2(STRETCH + 1);

  logic          accept;
  logic [15:0]   last_q, last_d;
  logic [15:0]   sel_val;
  logic [7:0]    disp_byte;
  logic [6:0]    seg_lo, seg_hi;
  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] str_q, str_d;
  logic          ledg_q, ledg_d;
  logic [6:0]    hex0_q, hex0_d, hex1_q, hex1_d;

  assign accept = enable & rIn;

`ifdef FIR_MON_PEAK_HOLD_EN
  logic [15:0] peak_q, peak_d;

  // A clear wins over a same-cycle sample; the sample still lands in last_q.
  always_comb begin
    peak_d = peak_q;
    if (enable) begin
      if (peak_clr)                        peak_d = '0;
      else if (rIn && (dataIn > peak_q))   peak_d = dataIn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) peak_q <= '0;
    else      peak_q <= peak_d;
  end

  assign sel_val = peak_sel ? peak_q : last_q;
`else
  logic unused_peak;
  assign unused_peak = peak_sel ^ peak_clr;
  assign sel_val     = last_q;
`endif

  assign disp_byte = (state_q == SHOW_HI) ? sel_val[15:8] : sel_val[7:0];

  seg7_decode u_seg_lo (.nib(disp_byte[3:0]), .seg(seg_lo));
  seg7_decode u_seg_hi (.nib(disp_byte[7:4]), .seg(seg_hi));

  always_comb begin
    last_d  = last_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    str_d   = str_q;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    if (enable) begin
      if (rIn) last_d = dataIn;
      if (cnt_q == DW'(DWELL - 1)) begin
        cnt_d   = '0;
        state_d = (state_q == SHOW_HI) ? SHOW_LO : SHOW_HI;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
      if (accept)              str_d = SW'(STRETCH);
      else if (str_q != '0)    str_d = str_q - SW'(1);
      hex0_d = seg_lo;
      hex1_d = seg_hi;
    end
    // Registered copy of "stretch counter nonzero" tracks the counter exactly.
    ledg_d = (str_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= '0;
      state_q <= SHOW_HI;
      cnt_q   <= '0;
      str_q   <= '0;
      ledg_q  <= 1'b0;
      hex0_q  <= SEG_ZERO;
      hex1_q  <= SEG_ZERO;
    end else begin
      last_q  <= last_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      str_q   <= str_d;
      ledg_q  <= ledg_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
    end
  end

  assign LEDG = ledg_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;

endmodule

// File: tb/tb_fir_out_monitor.sv
// Directed self-checking bench for fir_out_monitor with DWELL=4, STRETCH=3.
module tb_fir_out_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        rIn = 1'b0;
  logic [15:0] dataIn = '0;
  logic        peak_sel = 1'b0;
  logic        peak_clr = 1'b0;
  logic        LEDG;
  logic [6:0]  HEX0, HEX1;

  int n_cmp = 0;
  int n_bad = 0;
  int ph    = 0;  // enabled clock edges since reset release

`ifdef FIR_MON_PEAK_HOLD_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  fir_out_monitor #(.DWELL(4), .STRETCH(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rIn(rIn), .dataIn(dataIn),
    .peak_sel(peak_sel), .peak_clr(peak_clr),
    .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40; 4'h1: glyph = 7'h79; 4'h2: glyph = 7'h24; 4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19; 4'h5: glyph = 7'h12; 4'h6: glyph = 7'h02; 4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00; 4'h9: glyph = 7'h10; 4'hA: glyph = 7'h08; 4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46; 4'hD: glyph = 7'h21; 4'hE: glyph = 7'h06; default: glyph = 7'h0E;
    endcase
  endfunction

  // Expected {HEX1,HEX0} after enabled edge n: edge n shows the byte picked by the
  // state held after edge n-1, and the state flips every 4 edges starting at SHOW_HI.
  function automatic logic [13:0] exp_hex(input logic [15:0] v, input int n);
    logic [7:0] b;
    b = ((((n - 1) / 4) % 2) == 0) ? v[15:8] : v[7:0];
    return {glyph(b[7:4]), glyph(b[3:0])};
  endfunction

  task automatic tick();
    @(posedge clk); #1; ph++;
  endtask

  task automatic tick_hold();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b1; rIn = 1'b0; peak_sel = 1'b0; peak_clr = 1'b0;
    tick_hold(); tick_hold();
    rst = 1'b1; ph = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({LEDG, HEX1, HEX0} !== {1'b0, 7'h40, 7'h40}) begin
      n_bad++; $display("FAIL reset_state got %b_%h_%h want 0_40_40", LEDG, HEX1, HEX0);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    rIn = 1'b1; dataIn = 16'h12AB; tick(); rIn = 1'b0;
    n_cmp++;
    if ({HEX1, HEX0} !== exp_hex(16'h0000, ph) || LEDG !== 1'b1) begin
      n_bad++; $display("FAIL basic_first got %b_%h_%h want 1_40_40", LEDG, HEX1, HEX0);
    end
    for (int i = 2; i <= 16; i++) begin
      tick();
      n_cmp++;
      if ({HEX1, HEX0} !== exp_hex(16'h12AB, ph) || LEDG !== (ph <= 3)) begin
        n_bad++; $display("FAIL basic_cycle ph=%0d got %b_%h_%h want %b_%h", ph, LEDG, HEX1, HEX0,
                          (ph <= 3), exp_hex(16'h12AB, ph));
      end
    end
  endtask

  task automatic test_peak();
    logic [15:0] samples [3];
    logic [15:0] want;
    samples = '{16'h0100, 16'h0300, 16'h0200};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rIn = 1'b1; dataIn = samples[i]; tick();
    end
    rIn = 1'b0; peak_sel = 1'b1;
    want = PEAK ? 16'h0300 : 16'h0200;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({HEX1, HEX0} !== exp_hex(want, ph)) begin
        n_bad++; $display("FAIL peak_sel1 ph=%0d got %h_%h want %h", ph, HEX1, HEX0, exp_hex(want, ph));
      end
    end
    peak_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({HEX1, HEX0} !== exp_hex(16'h0200, ph)) begin
        n_bad++; $display("FAIL peak_sel0 ph=%0d got %h_%h want %h", ph, HEX1, HEX0, exp_hex(16'h0200, ph));
      end
    end
  endtask

  task automatic test_peak_clr();
    logic [15:0] want;
    peak_sel = 1'b1; peak_clr = 1'b1; rIn = 1'b1; dataIn = 16'h0050;
    tick();
    peak_clr = 1'b0; rIn = 1'b0;
    want = PEAK ? 16'h0000 : 16'h0050;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({HEX1, HEX0} !== exp_hex(want, ph)) begin
        n_bad++; $display("FAIL peak_clr ph=%0d got %h_%h want %h", ph, HEX1, HEX0, exp_hex(want, ph));
      end
    end
    peak_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({HEX1, HEX0} !== exp_hex(16'h0050, ph)) begin
        n_bad++; $display("FAIL clr_last ph=%0d got %h_%h want %h", ph, HEX1, HEX0, exp_hex(16'h0050, ph));
      end
    end
  endtask

  task automatic test_led();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rIn = (i == 0); tick(); rIn = 1'b0;
      n_cmp++;
      if (LEDG !== (i <= 2)) begin
        n_bad++; $display("FAIL led_single i=%0d got %b want %b", i, LEDG, (i <= 2));
      end
    end
    for (int i = 0; i < 7; i++) begin
      rIn = (i == 0 || i == 2); tick(); rIn = 1'b0;
      n_cmp++;
      if (LEDG !== (i <= 4)) begin
        n_bad++; $display("FAIL led_retrig i=%0d got %b want %b", i, LEDG, (i <= 4));
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    dataIn = 16'h12AB;
    for (int i = 1; i <= 6; i++) begin
      rIn = (i == 1 || i == 5); tick();
    end
    rIn = 1'b0;
    enable = 1'b0; dataIn = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      rIn = (i % 3 == 0); tick_hold();
      n_cmp++;
      if ({HEX1, HEX0} !== exp_hex(16'h12AB, 6) || LEDG !== 1'b1) begin
        n_bad++; $display("FAIL freeze i=%0d got %b_%h_%h want 1_%h", i, LEDG, HEX1, HEX0, exp_hex(16'h12AB, 6));
      end
    end
    rIn = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({HEX1, HEX0} !== exp_hex(16'h12AB, ph) || LEDG !== (ph == 7)) begin
        n_bad++; $display("FAIL resume ph=%0d got %b_%h_%h want %b_%h", ph, LEDG, HEX1, HEX0,
                          (ph == 7), exp_hex(16'h12AB, ph));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dataIn = 16'h12AB;
    for (int i = 1; i <= 5; i++) begin
      rIn = (i == 1 || i == 4); tick();
    end
    rIn = 1'b0;
    n_cmp++;
    if ({HEX1, HEX0} !== exp_hex(16'h12AB, 5) || LEDG !== 1'b1) begin
      n_bad++; $display("FAIL pre_rst got %b_%h_%h want 1_%h", LEDG, HEX1, HEX0, exp_hex(16'h12AB, 5));
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({LEDG, HEX1, HEX0} !== {1'b0, 7'h40, 7'h40}) begin
      n_bad++; $display("FAIL async_rst got %b_%h_%h want 0_40_40", LEDG, HEX1, HEX0);
    end
    tick_hold(); tick_hold();
    rst = 1'b1; ph = 0;
    rIn = 1'b1; tick(); rIn = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      tick();
      n_cmp++;
      if ({HEX1, HEX0} !== exp_hex(16'h12AB, ph)) begin
        n_bad++; $display("FAIL post_rst ph=%0d got %h_%h want %h", ph, HEX1, HEX0, exp_hex(16'h12AB, ph));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_peak();
    test_peak_clr();
    test_led();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
